// File: rtl/mips_pkg.sv
// Shared definitions for the memory-port arbiter and its watchdog.
package mips_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  // Arbiter ownership of the single memory port.
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_D = 2'd1,
    ARB_BUSY_I = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_access_watchdog.sv
// Counts BUSY cycles without mem_ready and abandons an access that hangs.
module mem_access_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic busy_i,
  input  logic ready_i,
  output logic expire_o,
  output logic timeout_err_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q;

  // Held at zero while idle, so every access starts from a clean count;
  // saturates at LAST so it can never wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (!busy_i)                       cnt_d = '0;
    else if (!ready_i && cnt_q != LAST) cnt_d = cnt_q + 1'b1;
  end

  assign expire_o      = busy_i & ~ready_i & (cnt_q == LAST);
  assign timeout_err_o = err_q;

  // Counter register and sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (expire_o) err_q <= 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the MEM stage.
// MEM (older instruction) wins ties; accesses are never pre-empted.
module mem_port_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                reset,
  // IF stage
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic                i_flush,
  output logic                i_stall,
  output logic                i_done,
  output logic [DATA_W-1:0]   i_rdata,
  // MEM stage
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_stall,
  output logic                d_done,
  output logic [DATA_W-1:0]   d_rdata,
  // memory port
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  output logic                timeout_err
);

  localparam int BE_W = DATA_W / 8;

  arb_state_e        state_q;
  logic              kill_q;
  logic              mem_req_q, mem_we_q;
  logic [BE_W-1:0]   mem_be_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              i_done_q, d_done_q;
  logic [DATA_W-1:0] i_rdata_q, d_rdata_q;

  logic busy, wd_expire, fetch_dead;

  assign busy = (state_q != ARB_IDLE);
  // A redirect arriving in the completing cycle also discards the fetch.
  assign fetch_dead = kill_q | i_flush;

  mem_access_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk          (clk),
    .reset        (reset),
    .busy_i       (busy),
    .ready_i      (mem_ready),
    .expire_o     (wd_expire),
    .timeout_err_o(timeout_err)
  );

  // Arbitration FSM with registered memory strobes and done/data returns.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      kill_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          kill_q <= 1'b0;
          // done guards: the requester still holds req during its done cycle
          if (d_req && !d_done_q) begin
            state_q     <= ARB_BUSY_D;
            mem_req_q   <= 1'b1;
            mem_we_q    <= d_we;
            mem_be_q    <= d_be;
            mem_addr_q  <= d_addr;
            mem_wdata_q <= d_wdata;
          end else if (i_req && !i_done_q && !i_flush) begin
            state_q     <= ARB_BUSY_I;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '1;
            mem_addr_q  <= i_addr;
            mem_wdata_q <= '0;
          end
        end
        ARB_BUSY_D: begin
          if (mem_ready || wd_expire) begin
            state_q   <= ARB_IDLE;
            mem_req_q <= 1'b0;
            d_done_q  <= 1'b1;
            d_rdata_q <= mem_ready ? mem_rdata : '0;
          end
        end
        ARB_BUSY_I: begin
          if (i_flush) kill_q <= 1'b1;
          if (mem_ready || wd_expire) begin
            state_q   <= ARB_IDLE;
            mem_req_q <= 1'b0;
            kill_q    <= 1'b0;
            if (!fetch_dead) begin
              i_done_q  <= 1'b1;
              i_rdata_q <= mem_ready ? mem_rdata : '0;
            end
          end
        end
        default: begin
          state_q   <= ARB_IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

  // Stalls drop the instant reset is asserted, so the pipeline is released
  // together with the abandoned access. A data access freezes fetch too.
  assign d_stall = ~reset & d_req & ~d_done_q;
  assign i_stall = ~reset & ((i_req & ~i_done_q) | d_stall | (state_q == ARB_BUSY_D));

endmodule
